// File: rtl/uart_disp_pkg.sv
// ============================================================================
// Module   : uart_disp_pkg
// Brief    : Shared types and constants for the UART receiver with hex display.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_disp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_t;

    localparam int c_PARITY_NONE = 0;
    localparam int c_PARITY_ODD  = 1;
    localparam int c_PARITY_EVEN = 2;

    // Active-low {A,B,C,D,E,F,G}, indexed by nibble value
    localparam logic [6:0] c_HEX_SEG [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_display_if.sv
// ============================================================================
// Module   : uart_rx_display_if
// Brief    : Valid/ready byte stream leaving the UART receiver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rx_display_if #(
    parameter int N_BITS = 8
) ();
    logic [N_BITS-1:0] tdata;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, output tvalid, input  tready);
    modport slave  (input  tdata, input  tvalid, output tready);
endinterface

`default_nettype wire

// File: rtl/hex7seg.sv
// ============================================================================
// Module   : hex7seg
// Brief    : Combinational nibble to active-low seven-segment decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hex7seg
    import uart_disp_pkg::*;
(
    input  wire logic [3:0] i_nibble,
    output logic      [6:0] o_seg
);
    assign o_seg = c_HEX_SEG[i_nibble];
endmodule

`default_nettype wire

// File: rtl/uart_rx_display.sv
// ============================================================================
// Module   : uart_rx_display
// Brief    : UART receiver with valid/ready output and a hex display of the
//            most recently consumed bytes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_display
    import uart_disp_pkg::*;
#(
    parameter int CLK_FREQ   = 25_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int N_BITS     = 8,
    parameter int PARITY     = 0,
    parameter int DISP_BYTES = 1
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    input  wire logic                    rx,
    uart_rx_display_if.master            axis,
    input  wire logic                    clear,
    output logic                         frame_err,
    output logic                         parity_err,
    output logic                         overrun,
    output logic [14*DISP_BYTES-1:0]     seg
);
    localparam int c_CPB  = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int c_HALF = c_CPB / 2;
    localparam int c_CW   = $clog2(c_CPB);
    localparam int c_DW   = 8 * DISP_BYTES;
    localparam logic [14*DISP_BYTES-1:0] c_SEG_RST = {(2*DISP_BYTES){7'b0000001}};

    if (c_CPB < 4 || N_BITS < 5 || N_BITS > 8 || PARITY < 0 || PARITY > 2 ||
        DISP_BYTES < 1 || DISP_BYTES > 4) begin : g_bad_params
        $error("uart_rx_display: illegal parameter set");
    end

    rx_state_t          r_state, w_state_nxt;
    logic               r_rx_meta, r_rx_sync, r_rx_prev;
    logic [c_CW-1:0]    r_cnt;
    logic [2:0]         r_bit_idx;
    logic [N_BITS-1:0]  r_shift, r_tdata;
    logic               r_frame_bad, r_deliver, r_tvalid;
    logic               r_frame_err, r_parity_err, r_overrun;
    logic [c_DW-1:0]    r_disp;
    logic [14*DISP_BYTES-1:0] w_seg_dec, r_seg_pipe, r_seg;
    logic               w_fall, w_tick, w_last_bit, w_par_exp, w_hs;
    logic               w_sample_data, w_par_fail, w_stop_bad, w_deliver;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_fall     = r_rx_prev & ~r_rx_sync;
    assign w_tick     = (r_state == ST_START) ? (r_cnt == c_CW'(c_HALF - 1))
                                              : (r_cnt == c_CW'(c_CPB - 1));
    assign w_last_bit = (r_bit_idx == 3'(N_BITS - 1));
    assign w_par_exp  = (PARITY == c_PARITY_ODD) ? ~^r_shift : ^r_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_fall) w_state_nxt = ST_START;
            ST_START:  if (w_tick) w_state_nxt = r_rx_sync ? ST_IDLE : ST_DATA;
            ST_DATA:   if (w_tick && w_last_bit)
                           w_state_nxt = (PARITY != c_PARITY_NONE) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (w_tick) w_state_nxt = ST_STOP;
            ST_STOP:   if (w_tick) w_state_nxt = r_rx_sync ? ST_IDLE : ST_BREAK;
            ST_BREAK:  if (r_rx_sync) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_sample_data = 1'b0;
        w_par_fail    = 1'b0;
        w_stop_bad    = 1'b0;
        w_deliver     = 1'b0;
        case (r_state)
            ST_DATA:   w_sample_data = w_tick;
            ST_PARITY: w_par_fail    = w_tick && (r_rx_sync != w_par_exp);
            ST_STOP: begin
                w_stop_bad = w_tick & ~r_rx_sync;
                w_deliver  = w_tick & r_rx_sync & ~r_frame_bad;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_frame_bad  <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_deliver    <= 1'b0;
        end else begin
            r_frame_err  <= w_stop_bad;
            r_parity_err <= w_par_fail;
            r_deliver    <= w_deliver;
            // Counter idles at zero so START always begins a fresh half-bit count
            if (r_state == ST_IDLE || r_state == ST_BREAK || w_tick) r_cnt <= '0;
            else                                                      r_cnt <= r_cnt + c_CW'(1);
            if (r_state == ST_IDLE) begin
                r_bit_idx   <= '0;
                r_frame_bad <= 1'b0;
            end
            if (w_sample_data) begin
                r_shift   <= {r_rx_sync, r_shift[N_BITS-1:1]};
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            if (w_par_fail) r_frame_bad <= 1'b1;
        end
    end

    assign w_hs = r_tvalid & axis.tready;

    // A delivery coinciding with a handshake replaces the byte without overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tdata   <= '0;
            r_tvalid  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_deliver) begin
                if (r_tvalid && !axis.tready) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_tdata  <= r_shift;
                    r_tvalid <= 1'b1;
                end
            end else if (w_hs) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_disp <= '0;
        else if (clear)  r_disp <= '0;
        else if (w_hs)   r_disp <= (r_disp << 8) | c_DW'(r_tdata);
    end

    for (genvar i = 0; i < 2*DISP_BYTES; i++) begin : g_digit
        hex7seg u_hex7seg (
            .i_nibble (r_disp[4*i +: 4]),
            .o_seg    (w_seg_dec[7*i +: 7])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_pipe <= c_SEG_RST;
            r_seg      <= c_SEG_RST;
        end else begin
            r_seg_pipe <= w_seg_dec;
            r_seg      <= r_seg_pipe;
        end
    end

    assign axis.tdata  = r_tdata;
    assign axis.tvalid = r_tvalid;
    assign frame_err   = r_frame_err;
    assign parity_err  = r_parity_err;
    assign overrun     = r_overrun;
    assign seg         = r_seg;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_display.sv
// ============================================================================
// Module   : tb_uart_rx_display
// Brief    : Directed scoreboard bench: default DUT (u_a) and even-parity,
//            two-byte-display DUT (u_b).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx_display;
    import uart_disp_pkg::*;

    localparam int c_CPB = 217;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_a = 1'b1, rx_b = 1'b1;
    logic        clear_a = 1'b0, clear_b = 1'b0;
    logic        fe_a, pe_a, ov_a, fe_b, pe_b, ov_b;
    logic [13:0] seg_a;
    logic [27:0] seg_b;

    int n_cmp = 0, n_bad = 0;
    int hs_a = 0, hs_b = 0;
    int fe_cnt_a = 0, pe_cnt_a = 0, ov_cnt_a = 0;
    int fe_cnt_b = 0, pe_cnt_b = 0, ov_cnt_b = 0;
    logic [7:0] q_a[$], q_b[$];

    uart_rx_display_if #(.N_BITS(8)) if_a ();
    uart_rx_display_if #(.N_BITS(8)) if_b ();

    uart_rx_display #(.PARITY(0), .DISP_BYTES(1)) u_a (
        .clk(clk), .rst_n(rst_n), .rx(rx_a), .axis(if_a), .clear(clear_a),
        .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a), .seg(seg_a)
    );

    uart_rx_display #(.PARITY(2), .DISP_BYTES(2)) u_b (
        .clk(clk), .rst_n(rst_n), .rx(rx_b), .axis(if_b), .clear(clear_b),
        .frame_err(fe_b), .parity_err(pe_b), .overrun(ov_b), .seg(seg_b)
    );

    always #20 clk = ~clk;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;  default: return 7'b0111000;
        endcase
    endfunction

    function automatic logic [13:0] seg_byte(input logic [7:0] b);
        return {seg7(b[7:4]), seg7(b[3:0])};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bit_time();
        repeat (c_CPB) @(posedge clk);
        #1;
    endtask

    task automatic drive_rx(input bit to_b, input logic v);
        if (to_b) rx_b = v;
        else      rx_a = v;
    endtask

    // Leaves the line at the stop level; caller decides how long to hold it
    task automatic send_frame(input bit to_b, input logic [7:0] d, input bit par_en,
                              input logic par_bit, input logic stop_bit);
        drive_rx(to_b, 1'b0);
        bit_time();
        for (int i = 0; i < 8; i++) begin
            drive_rx(to_b, d[i]);
            bit_time();
        end
        if (par_en) begin
            drive_rx(to_b, par_bit);
            bit_time();
        end
        drive_rx(to_b, stop_bit);
    endtask

    task automatic wait_valid_a(input int max_cyc);
        int n;
        n = 0;
        @(negedge clk);
        while (!if_a.tvalid && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk("tvalid_a_timeout", 32'(if_a.tvalid), 1);
    endtask

    // Scoreboard pop and error-pulse tallies
    always @(negedge clk) begin
        if (rst_n) begin
            if (if_a.tvalid && if_a.tready) begin
                hs_a++;
                if (q_a.size() == 0) chk("sb_a_qsize", 32'(q_a.size()), 1);
                else                 chk("sb_a_data", 32'(if_a.tdata), 32'(q_a.pop_front()));
            end
            if (if_b.tvalid && if_b.tready) begin
                hs_b++;
                if (q_b.size() == 0) chk("sb_b_qsize", 32'(q_b.size()), 1);
                else                 chk("sb_b_data", 32'(if_b.tdata), 32'(q_b.pop_front()));
            end
            if (fe_a) fe_cnt_a++;
            if (pe_a) pe_cnt_a++;
            if (ov_a) ov_cnt_a++;
            if (fe_b) fe_cnt_b++;
            if (pe_b) pe_cnt_b++;
            if (ov_b) ov_cnt_b++;
        end
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        if_a.tready = 1'b1;
        if_b.tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid_a", 32'(if_a.tvalid), 0);
        chk("rst_tdata_a",  32'(if_a.tdata), 0);
        chk("rst_seg_a",    32'(seg_a), 32'({2{7'b0000001}}));
        chk("rst_seg_b",    32'(seg_b), 32'({4{7'b0000001}}));
        chk("rst_err_a",    32'({fe_a, pe_a, ov_a}), 0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // 0xA5 delivered once; display follows two clocks after the handshake
        q_a.push_back(8'hA5);
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
        wait_valid_a(2*c_CPB);
        @(posedge clk); #1;
        chk("a5_tvalid_drop", 32'(if_a.tvalid), 0);
        @(posedge clk); #1;
        chk("a5_seg_h1", 32'(seg_a), 32'({2{7'b0000001}}));
        @(posedge clk); #1;
        chk("a5_seg_h2", 32'(seg_a), 32'(seg_byte(8'hA5)));
        bit_time(); bit_time();
        chk("a5_hs_once", hs_a, 1);

        // Overrun: 0x12 held, 0x34 dropped
        if_a.tready = 1'b0;
        q_a.push_back(8'h12);
        send_frame(1'b0, 8'h12, 1'b0, 1'b0, 1'b1);
        bit_time();
        send_frame(1'b0, 8'h34, 1'b0, 1'b0, 1'b1);
        bit_time(); bit_time();
        chk("ov_tdata",  32'(if_a.tdata), 32'h12);
        chk("ov_tvalid", 32'(if_a.tvalid), 1);
        chk("ov_count",  ov_cnt_a, 1);
        if_a.tready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("ov_seg",    32'(seg_a), 32'(seg_byte(8'h12)));
        chk("ov_hs",     hs_a, 2);

        // Framing error then line held low: stays in BREAK until rx high
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
        repeat (5) bit_time();
        chk("brk_state",  32'(u_a.r_state), 32'(ST_BREAK));
        chk("brk_fe",     fe_cnt_a, 1);
        chk("brk_tvalid", 32'(if_a.tvalid), 0);
        rx_a = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("brk_exit", 32'(u_a.r_state), 32'(ST_IDLE));
        bit_time();
        q_a.push_back(8'h3C);
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
        bit_time();
        chk("recover_seg", 32'(seg_a), 32'(seg_byte(8'h3C)));

        // 50-clock glitch on idle line
        rx_a = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        rx_a = 1'b1;
        bit_time(); bit_time();
        chk("glitch_hs",  hs_a, 3);
        chk("glitch_err", fe_cnt_a + pe_cnt_a + ov_cnt_a, 2);

        // Even parity: 0x07 with parity bit 0 is rejected
        send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
        bit_time();
        chk("par_pe",     pe_cnt_b, 1);
        chk("par_hs",     hs_b, 0);
        chk("par_tvalid", 32'(if_b.tvalid), 0);

        q_b.push_back(8'h12);
        send_frame(1'b1, 8'h12, 1'b1, ^8'h12, 1'b1);
        bit_time();
        q_b.push_back(8'h34);
        send_frame(1'b1, 8'h34, 1'b1, ^8'h34, 1'b1);
        bit_time();
        chk("d2_seg",   32'(seg_b), 32'({seg_byte(8'h12), seg_byte(8'h34)}));
        chk("d2_errs",  fe_cnt_b + pe_cnt_b + ov_cnt_b, 1);
        clear_b = 1'b1;
        @(posedge clk); #1;
        clear_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("d2_clear", 32'(seg_b), 32'({4{7'b0000001}}));

        // Reset asserted in the middle of a frame on u_b
        rx_b = 1'b0;
        bit_time();
        rx_b = 1'b1;
        bit_time();
        rx_b = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_state_b",  32'(u_b.r_state), 32'(ST_IDLE));
        chk("mrst_tdata_b",  32'(if_b.tdata), 0);
        chk("mrst_tdata_a",  32'(if_a.tdata), 0);
        chk("mrst_seg_a",    32'(seg_a), 32'({2{7'b0000001}}));
        chk("mrst_err_b",    32'({fe_b, pe_b, ov_b, if_b.tvalid}), 0);
        rx_b = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (12) bit_time();
        chk("mrst_hs_b",     hs_b, 2);
        chk("mrst_errcnt_b", fe_cnt_b + pe_cnt_b + ov_cnt_b, 1);
        chk("mrst_tvalid_b", 32'(if_b.tvalid), 0);

        chk("sb_a_empty", 32'(q_a.size()), 0);
        chk("sb_b_empty", 32'(q_b.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
